// File: rtl/button_hex_counter_pkg.sv
// Shared constants for the button hex counter.
//   - SEG_0..SEG_F : active-low 7-segment codes, bit order gfedcba (seg[0]=a).
//   - ANODE_DIGIT0 : active-low anode pattern that lights only the rightmost digit.
//   - DEBOUNCE_CYCLES_DEF / CNT_W_DEF : default debounce length and counter width.
package button_hex_counter_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 65536;
    localparam int CNT_W_DEF           = 17;

    localparam logic [2:0] ANODE_DIGIT0 = 3'b110;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/button_hex_counter_debouncer.sv
// Two-flop synchronizer followed by a stability counter.
//   clk   : system clock
//   rst   : synchronous active-high reset
//   raw   : asynchronous, bouncing button input
//   level : debounced button level (registered)
// The level only follows the synchronized input after it has differed from
// the current level for DEBOUNCE_CYCLES consecutive cycles; any return to
// the current level restarts the count.
import button_hex_counter_pkg::*;

module debouncer #(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // Held the new level for the full window: accept it.
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/button_hex_counter.sv
// Counts debounced presses of btnU and shows the 4-bit count as one hex
// digit on the rightmost 7-segment display.
//   clk  : system clock, rising edge
//   btnC : synchronous active-high reset
//   btnU : raw count button, high = pressed
//   seg  : active-low segments, seg[0]=a .. seg[6]=g
//   led  : led[0] = debounced button level
//   an   : active-low anodes, always 3'b110
import button_hex_counter_pkg::*;

module button_hex_counter #(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       btnC,
    input  logic       btnU,
    output logic [6:0] seg,
    output logic [0:0] led,
    output logic [2:0] an
);

    logic       level;
    logic       level_d1;
    logic       press;
    logic [3:0] count;

    debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debouncer (
        .clk   (clk),
        .rst   (btnC),
        .raw   (btnU),
        .level (level)
    );

    // Rising edge of the debounced level: one cycle wide, releases ignored.
    assign press = level & ~level_d1;

    always_ff @(posedge clk) begin
        if (btnC) begin
            level_d1 <= 1'b0;
            count    <= 4'h0;
        end else begin
            level_d1 <= level;
            if (press)
                count <= count + 4'h1;   // wraps F -> 0 naturally
        end
    end

    always_comb begin
        seg = SEG_0;
        case (count)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_0;
        endcase
    end

    assign led[0] = level;
    assign an     = ANODE_DIGIT0;

endmodule

// File: tb/tb_button_hex_counter.sv
module tb_button_hex_counter;

    localparam int DB = 16;

    logic       clk = 1'b0;
    logic       btnC;
    logic       btnU;
    logic [6:0] seg;
    logic [0:0] led;
    logic [2:0] an;

    int n_vec = 0;
    int n_err = 0;

    logic [6:0] seg_tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic [6:0] exp_q [$];
    logic [3:0] exp_cnt = 4'h0;
    logic       mon_en  = 1'b0;
    logic [6:0] prev_seg;

    button_hex_counter #(.DEBOUNCE_CYCLES(DB), .CNT_W(17)) dut (
        .clk  (clk),
        .btnC (btnC),
        .btnU (btnU),
        .seg  (seg),
        .led  (led),
        .an   (an)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Every display change must match the next queued expectation.
    always @(negedge clk) begin
        if (mon_en && seg !== prev_seg) begin
            if (exp_q.size() == 0)
                chk("spurious_seg", {25'd0, seg}, {25'd0, prev_seg});
            else
                chk("seg_update", {25'd0, seg}, {25'd0, exp_q.pop_front()});
            prev_seg = seg;
        end
    end

    task automatic drive(input logic v, input int n);
        btnU = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_inc();
        exp_cnt = exp_cnt + 4'h1;
        exp_q.push_back(seg_tbl[exp_cnt]);
    endtask

    task automatic clean_press();
        expect_inc();
        drive(1'b1, 40);
        drive(1'b0, 40);
    endtask

    task automatic bounce_press();
        expect_inc();
        drive(1'b1, 1); drive(1'b0, 1); drive(1'b1, 2); drive(1'b0, 10); drive(1'b1, 4);
        chk("bounce_press_led", {31'd0, led[0]}, 32'd0);
        drive(1'b1, 50);
        chk("hold_led", {31'd0, led[0]}, 32'd1);
        drive(1'b0, 1); drive(1'b1, 1); drive(1'b0, 2); drive(1'b1, 10); drive(1'b0, 4);
        chk("bounce_release_led", {31'd0, led[0]}, 32'd1);
        drive(1'b0, 50);
        chk("release_led", {31'd0, led[0]}, 32'd0);
    endtask

    initial begin
        btnC = 1'b1;
        btnU = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("an_in_reset", {29'd0, an}, 32'd6);
        btnC = 1'b0;
        @(posedge clk); #1;
        chk("rst_seg", {25'd0, seg}, {25'd0, seg_tbl[0]});
        chk("rst_led", {31'd0, led[0]}, 32'd0);
        chk("rst_an", {29'd0, an}, 32'd6);
        prev_seg = seg;
        mon_en   = 1'b1;

        // Clean press with exact latency: 2 sync + DB + 1 edges.
        expect_inc();
        btnU = 1'b1;
        repeat (DB + 2) @(posedge clk);
        #1;
        chk("lat_before", {25'd0, seg}, {25'd0, seg_tbl[0]});
        chk("led_at_level", {31'd0, led[0]}, 32'd1);
        @(posedge clk); #1;
        chk("lat_exact", {25'd0, seg}, {25'd0, seg_tbl[1]});
        drive(1'b1, 21);
        drive(1'b0, 40);
        chk("clean_release_led", {31'd0, led[0]}, 32'd0);

        bounce_press();
        bounce_press();

        // Reset back to 0, then wrap through all 16 values.
        exp_cnt = 4'h0;
        exp_q.push_back(seg_tbl[0]);
        btnC = 1'b1;
        @(posedge clk); #1;
        btnC = 1'b0;
        for (int i = 0; i < 16; i++) clean_press();
        chk("wrap_seg", {25'd0, seg}, {25'd0, seg_tbl[0]});

        // Reach 5 with the button still held, then reset mid-press.
        for (int i = 0; i < 4; i++) clean_press();
        expect_inc();
        drive(1'b1, 30);
        chk("held_led", {31'd0, led[0]}, 32'd1);
        exp_cnt = 4'h0;
        exp_q.push_back(seg_tbl[0]);
        btnC = 1'b1;
        @(posedge clk); #1;
        chk("midrst_led", {31'd0, led[0]}, 32'd0);
        chk("midrst_seg", {25'd0, seg}, {25'd0, seg_tbl[0]});
        chk("midrst_an", {29'd0, an}, 32'd6);
        btnC = 1'b0;
        expect_inc();
        drive(1'b1, DB + 2);
        chk("redebounce_wait", {25'd0, seg}, {25'd0, seg_tbl[0]});
        drive(1'b1, 30);
        chk("redebounce_seg", {25'd0, seg}, {25'd0, seg_tbl[1]});
        drive(1'b0, 40);

        chk("queue_drained", exp_q.size(), 32'd0);
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/button_hex_counter.md
Name: button_hex_counter

Overview:
- Board-level top block that counts debounced presses of one push-button and shows the 4-bit count as one hex digit on a 7-segment display.
- Inputs:
  - btnC: synchronous reset.
  - btnU: raw, bouncy, asynchronous count button.
- Outputs:
  - seg: active-low segment cathodes.
  - an: active-low anode selects; only the rightmost digit is lit.
  - led[0]: mirrors the debounced button level.

Parameters:
- DEBOUNCE_CYCLES, 65536, consecutive clk cycles the synchronized button must hold a new level before the debounced level changes. Default is about 0.66 ms at 100 MHz and 1.3 ms at 50 MHz, which is longer than any bounce interval (≤50 µs) and shorter than a genuine press (≥2 ms).
- CNT_W, 17, width of the debounce counter (enough bits for DEBOUNCE_CYCLES).

Ports:
- clk   input  1  system clock, 100 MHz nominal; all logic on rising edge.
- btnC  input  1  reset; synchronous, active-high.
- btnU  input  1  raw count button, asynchronous, bouncing; high = pressed.
- seg   output 7  segments, active-low; seg[0]=a … seg[6]=g.
- led   output 1  led[0] = debounced button level.
- an    output 3  anodes, active-low; constant 3'b110.

Interface (already decided): one clock; reset is synchronous and active-high. Clock port is clk, reset port is btnC.

Behaviour:
- Reset (btnC high at a clk edge) sets:
  - synchronizer flops 0, debounce counter 0, debounced level 0, edge-detect flop 0, count 4'h0;
  - hence led=0, seg=7'b1000000 ("0"), an=3'b110.
- Reset overrides everything else in the same cycle. Reset mid-press: after release of btnC, a button still held must first be re-debounced (full DEBOUNCE_CYCLES) before any increment.
- Synchronizer: btnU passes through 2 flops (sync1, sync2). Only sync2 is used downstream.
- Debouncer, each cycle:
  - if sync2 == debounced level: counter cleared to 0;
  - otherwise counter increments; when it reaches DEBOUNCE_CYCLES-1, the debounced level takes sync2 and the counter clears.
  - Any return to the old level before that clears the counter, so the glitch is ignored.
- Edge detect: press pulse = debounced level & ~debounced_d1; it is one cycle wide.
- Counter: 4-bit count increments by 1 on the cycle after the press pulse.
  - Wraps 4'hF → 4'h0.
  - Releases never count.
- Latency from the first stable sync2 high to the count update: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
- Decoder: combinational, registered output optional (if registered, +1 cycle latency, same reset value). Active-low codes, seg[6:0] = gfedcba:
  - 0:1000000  1:1111001  2:0100100  3:0110000
  - 4:0011001  5:0010010  6:0000010  7:1111000
  - 8:0000000  9:0010000  A:0001000  b:0000011
  - C:1000110  d:0100001  E:0000110  F:0001110
- led[0] = debounced level, registered.
- an is constant 3'b110, including during reset.
- Simultaneous btnC and btnU activity: reset wins; the button is ignored that cycle.

Decomposition:
- Shared package:
  - the 16-entry segment code constants (SEG_0..SEG_F);
  - the ANODE_DIGIT0 = 3'b110 constant;
  - the DEBOUNCE_CYCLES default.
- One sub-module, debouncer (synchronizer + stability counter + level output, parameterised by DEBOUNCE_CYCLES). Instantiated once.
- Counter, edge detect and hex decoder stay in the top.

Test Plan (benches run with DEBOUNCE_CYCLES=16 except where noted; clk period 10 ns):
- Reset: pulse btnC for 1 cycle → seg=7'b1000000, led=0, an=3'b110, count 0.
- Clean press: btnU high for 40 cycles, then low → exactly one increment; seg=7'b1111001 ("1") 19 cycles after btnU rose; led high while debounced-pressed.
- Bounce rejection: on both press and release, toggle btnU with high/low widths of 1, 1, 2, 10 and 4 cycles, then hold 50 cycles → one increment per press, none on release; widths under 16 never change led.
- Wrap: 16 clean presses from reset → seg steps through 1..9, A, b, C, d, E, F (F = 7'b0001110), then 0 (7'b1000000).
- Reset mid-operation: at count 5, assert btnC while btnU is held → count 0 and led 0; after btnC drops, the held button yields exactly one increment once debounced.
- Default parameters at 50 MHz: 15 presses of 2 ms high / 10 ms low, each edge with 1/1/2/10/4/50 µs bounce → final display F.
